// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/lap/clear sequencer: button conditioning, mode FSM,
// count-enable prescaler and clear/freeze generation.
module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int TICK_DIV        = 10,
    parameter int LONG_PRESS      = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_lap,
    output logic       tick,
    output logic       clr,
    output logic       disp_freeze,
    output logic       running,
    output logic [1:0] state
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(TICK_DIV);
    localparam int HW = $clog2(LONG_PRESS + 1);

    localparam logic [DW-1:0] DMAX  = DW'(DEBOUNCE_CYCLES);
    localparam logic [TW-1:0] TMAX  = TW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HMAX  = HW'(LONG_PRESS);
    localparam logic [HW-1:0] HTRIG = HW'(LONG_PRESS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    // bit 0 = start button, bit 1 = lap button
    logic [1:0]         sync1;
    logic [1:0]         sync2;
    logic [1:0]         deb;
    logic [1:0]         deb_q;
    logic [1:0][DW-1:0] dcnt;
    logic [HW-1:0]      hold;
    logic [TW-1:0]      pre;

    state_t state_q;
    state_t state_nx;
    logic   clr_nx;
    logic   start_evt;
    logic   lap_evt;
    logic   long_evt;
    logic   run_now;
    logic   run_nx;

    assign start_evt = deb[0] & ~deb_q[0];
    assign lap_evt   = deb[1] & ~deb_q[1];
    assign long_evt  = deb[0] && (hold == HTRIG);

    assign run_now = (state_q == RUN) || (state_q == LAP);
    assign run_nx  = (state_nx == RUN) || (state_nx == LAP);

    assign state = state_q;

    // Two-flop synchronizer for the raw buttons
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {btn_lap, btn_start};
            sync2 <= sync1;
        end
    end

    // Debounce: accept a new level after DEBOUNCE_CYCLES disagreeing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb   <= '0;
            deb_q <= '0;
            dcnt  <= '0;
        end else begin
            deb_q <= deb;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DMAX) begin
                    deb[i]  <= sync2[i];
                    dcnt[i] <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + 1'b1;
                end
            end
        end
    end

    // Hold counter for the long-press clear, saturating so it fires once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold <= '0;
        end else if (!deb[0]) begin
            hold <= '0;
        end else if (hold != HMAX) begin
            hold <= hold + 1'b1;
        end
    end

    // Next-state logic: long press beats start, start beats lap
    always_comb begin
        state_nx = state_q;
        clr_nx   = 1'b0;
        if (long_evt) begin
            state_nx = IDLE;
            clr_nx   = 1'b1;
        end else if (start_evt) begin
            state_nx = run_now ? PAUSE : RUN;
        end else if (lap_evt) begin
            case (state_q)
                RUN:     state_nx = LAP;
                LAP:     state_nx = RUN;
                PAUSE: begin
                    state_nx = IDLE;
                    clr_nx   = 1'b1;
                end
                default: state_nx = state_q;
            endcase
        end
    end

    // State register and registered mode outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            running     <= 1'b0;
            disp_freeze <= 1'b0;
            clr         <= 1'b0;
        end else begin
            state_q     <= state_nx;
            running     <= run_nx;
            disp_freeze <= (state_nx == LAP);
            clr         <= clr_nx;
        end
    end

    // Prescaler: advances only across cycles that stay counting,
    // holds through PAUSE and is zeroed on entry to IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= 1'b0;
            if ((state_nx == IDLE) || clr_nx) begin
                pre <= '0;
            end else if (run_now && run_nx) begin
                if (pre == TMAX) begin
                    pre  <= '0;
                    tick <= 1'b1;
                end else begin
                    pre <= pre + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with an event-level reference
// model that predicts mode, clear and tick from button press timing.
module tb_stopwatch_ctrl;

    localparam int D = 4;
    localparam int T = 5;
    localparam int L = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_start;
    logic       btn_lap;
    logic       tick;
    logic       clr;
    logic       disp_freeze;
    logic       running;
    logic [1:0] state;
    logic [5:0] obs;

    stopwatch_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .TICK_DIV(T),
        .LONG_PRESS(L)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_start(btn_start),
        .btn_lap(btn_lap),
        .tick(tick),
        .clr(clr),
        .disp_freeze(disp_freeze),
        .running(running),
        .state(state)
    );

    always #5 clk = ~clk;

    assign obs = {state, running, disp_freeze, clr, tick};

    int n_cmp = 0;
    int n_bad = 0;

    // reference model
    int         edge_n;
    int         srun;
    int         lrun;
    int         adv;
    logic [1:0] m_state;
    logic       m_clr;
    logic       m_tick;
    bit         sev[int];
    bit         lev[int];
    bit         gev[int];
    logic [1:0] wave[$];

    function automatic logic [5:0] exp_vec();
        return {m_state, (m_state == 2'd1) || (m_state == 2'd3),
                m_state == 2'd3, m_clr, m_tick};
    endfunction

    function automatic void model_reset();
        edge_n  = 0;
        srun    = 0;
        lrun    = 0;
        adv     = 0;
        m_state = 2'd0;
        m_clr   = 1'b0;
        m_tick  = 1'b0;
        sev.delete();
        lev.delete();
        gev.delete();
    endfunction

    // Apply the mode rules to the events that land on edge e
    function automatic void model_edge(int e);
        logic [1:0] ns;
        logic       c;
        logic       was_run;
        logic       is_run;
        ns      = m_state;
        c       = 1'b0;
        was_run = (m_state == 2'd1) || (m_state == 2'd3);
        if (gev.exists(e)) begin
            ns = 2'd0;
            c  = 1'b1;
        end else if (sev.exists(e)) begin
            ns = was_run ? 2'd2 : 2'd1;
        end else if (lev.exists(e)) begin
            case (m_state)
                2'd1: ns = 2'd3;
                2'd3: ns = 2'd1;
                2'd2: begin
                    ns = 2'd0;
                    c  = 1'b1;
                end
                default: ns = m_state;
            endcase
        end
        is_run = (ns == 2'd1) || (ns == 2'd3);
        m_tick = 1'b0;
        if (ns == 2'd0) begin
            adv = 0;
        end else if (was_run && is_run) begin
            adv++;
            if (adv == T) begin
                adv    = 0;
                m_tick = 1'b1;
            end
        end
        m_state = ns;
        m_clr   = c;
    endfunction

    // One clock of stimulus; the sample taken at edge k schedules the
    // debounced events that the press latency rules predict
    task automatic drive_cycle(input logic [1:0] v);
        int k;
        @(negedge clk);
        btn_start = v[0];
        btn_lap   = v[1];
        k = edge_n + 1;
        srun = v[0] ? srun + 1 : 0;
        lrun = v[1] ? lrun + 1 : 0;
        if (srun == D + 1) sev[k + 3] = 1'b1;
        if (srun == L)     gev[k + D + 3] = 1'b1;
        if (lrun == D + 1) lev[k + 3] = 1'b1;
        @(posedge clk);
        edge_n = k;
        model_edge(k);
        #1;
    endtask

    task automatic add_idle(input int n);
        repeat (n) wave.push_back(2'b00);
    endtask

    task automatic add_press(input logic [1:0] m, input int len);
        repeat (len) wave.push_back(m);
        add_idle($urandom_range(D + 2, D + 12));
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        btn_start = 1'b0;
        btn_lap   = 1'b0;
        model_reset();
        repeat (3) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (obs !== 6'b0) begin
                n_bad++;
                $display("FAIL reset got=%b want=%b", obs, 6'b0);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        wave.delete();
        add_idle(6);
        foreach (wave[i]) begin
            drive_cycle(wave[i]);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL reset_idle edge=%0d got=%b want=%b",
                         edge_n, obs, exp_vec());
            end
        end
    endtask

    task automatic test_start();
        int base;
        int first_run;
        int first_tick;
        int clr_seen;
        first_run  = -1;
        first_tick = -1;
        clr_seen   = 0;
        wave.delete();
        repeat (10) wave.push_back(2'b01);
        add_idle(30);
        base = edge_n + 1;
        foreach (wave[i]) begin
            drive_cycle(wave[i]);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL start_run edge=%0d got=%b want=%b",
                         edge_n, obs, exp_vec());
            end
            if (running && first_run < 0) first_run = edge_n - base;
            if (tick && first_tick < 0) first_tick = edge_n - base;
            if (clr) clr_seen++;
        end
        n_cmp++;
        if (first_run !== D + 3) begin
            n_bad++;
            $display("FAIL start_latency got=%0d want=%0d", first_run, D + 3);
        end
        n_cmp++;
        if (first_tick - first_run !== T) begin
            n_bad++;
            $display("FAIL first_tick got=%0d want=%0d",
                     first_tick - first_run, T);
        end
        n_cmp++;
        if (clr_seen !== 0) begin
            n_bad++;
            $display("FAIL start_clr got=%0d want=0", clr_seen);
        end
    endtask

    task automatic test_glitch_pause();
        wave.delete();
        add_press(2'b01, $urandom_range(1, D - 1));
        add_press(2'b10, $urandom_range(1, D - 1));
        add_press(2'b01, $urandom_range(D + 2, 10));
        add_idle($urandom_range(3, 12));
        add_press(2'b01, $urandom_range(D + 2, 10));
        add_idle(12);
        foreach (wave[i]) begin
            drive_cycle(wave[i]);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL glitch_pause edge=%0d got=%b want=%b",
                         edge_n, obs, exp_vec());
            end
        end
        n_cmp++;
        if (state !== 2'd1) begin
            n_bad++;
            $display("FAIL glitch_pause_end got=%0d want=1", state);
        end
    endtask

    task automatic test_lap();
        wave.delete();
        add_press(2'b10, $urandom_range(D + 2, 9));
        add_idle(8);
        foreach (wave[i]) begin
            drive_cycle(wave[i]);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL lap_enter edge=%0d got=%b want=%b",
                         edge_n, obs, exp_vec());
            end
        end
        n_cmp++;
        if ({state, disp_freeze} !== 3'b111) begin
            n_bad++;
            $display("FAIL lap_freeze got=%b want=111", {state, disp_freeze});
        end
        wave.delete();
        add_press(2'b10, $urandom_range(D + 2, 9));
        foreach (wave[i]) begin
            drive_cycle(wave[i]);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL lap_exit edge=%0d got=%b want=%b",
                         edge_n, obs, exp_vec());
            end
        end
        n_cmp++;
        if ({state, disp_freeze} !== 3'b010) begin
            n_bad++;
            $display("FAIL lap_unfreeze got=%b want=010", {state, disp_freeze});
        end
    endtask

    task automatic test_pause_clear();
        int clr_seen;
        clr_seen = 0;
        wave.delete();
        add_press(2'b01, $urandom_range(D + 2, 9));
        add_press(2'b10, $urandom_range(D + 2, 9));
        add_idle(10);
        foreach (wave[i]) begin
            drive_cycle(wave[i]);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL pause_clear edge=%0d got=%b want=%b",
                         edge_n, obs, exp_vec());
            end
            if (clr) clr_seen++;
        end
        n_cmp++;
        if (clr_seen !== 1) begin
            n_bad++;
            $display("FAIL pause_clr_count got=%0d want=1", clr_seen);
        end
        n_cmp++;
        if (state !== 2'd0) begin
            n_bad++;
            $display("FAIL pause_clear_end got=%0d want=0", state);
        end
    endtask

    task automatic test_simultaneous();
        int frz_seen;
        frz_seen = 0;
        wave.delete();
        add_press(2'b01, $urandom_range(D + 2, 9));
        add_idle(7);
        add_press(2'b11, $urandom_range(D + 2, 9));
        foreach (wave[i]) begin
            drive_cycle(wave[i]);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL simultaneous edge=%0d got=%b want=%b",
                         edge_n, obs, exp_vec());
            end
            if (disp_freeze) frz_seen++;
        end
        n_cmp++;
        if (state !== 2'd2 || frz_seen !== 0) begin
            n_bad++;
            $display("FAIL simultaneous_end got=%0d/%0d want=2/0",
                     state, frz_seen);
        end
    endtask

    task automatic test_long_press();
        int base;
        int first_run;
        int clr_seen;
        first_run = -1;
        clr_seen  = 0;
        wave.delete();
        add_press(2'b10, D + 3);
        foreach (wave[i]) begin
            drive_cycle(wave[i]);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL long_prep edge=%0d got=%b want=%b",
                         edge_n, obs, exp_vec());
            end
        end
        wave.delete();
        repeat (60) wave.push_back(2'b01);
        add_idle(30);
        base = edge_n + 1;
        foreach (wave[i]) begin
            drive_cycle(wave[i]);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL long_press edge=%0d got=%b want=%b",
                         edge_n, obs, exp_vec());
            end
            if (running && first_run < 0) first_run = edge_n - base;
            if (clr) clr_seen++;
        end
        n_cmp++;
        if (first_run !== D + 3) begin
            n_bad++;
            $display("FAIL long_latency got=%0d want=%0d", first_run, D + 3);
        end
        n_cmp++;
        if (clr_seen !== 1 || state !== 2'd0) begin
            n_bad++;
            $display("FAIL long_clear got=%0d/%0d want=1/0", clr_seen, state);
        end
    endtask

    task automatic test_random();
        int r;
        wave.delete();
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 3)      add_press(2'b01, $urandom_range(D + 2, 12));
            else if (r <= 6) add_press(2'b10, $urandom_range(D + 2, 12));
            else if (r == 7) add_press(2'b11, $urandom_range(D + 2, 12));
            else if (r == 8) add_press(2'(1 << $urandom_range(0, 1)),
                                       $urandom_range(1, D - 1));
            else             add_press(2'b01, $urandom_range(L, L + 10));
        end
        foreach (wave[i]) begin
            drive_cycle(wave[i]);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL random edge=%0d got=%b want=%b",
                         edge_n, obs, exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        wave.delete();
        if (m_state != 2'd1 && m_state != 2'd3) add_press(2'b01, D + 3);
        add_idle(12);
        foreach (wave[i]) begin
            drive_cycle(wave[i]);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL async_prep edge=%0d got=%b want=%b",
                         edge_n, obs, exp_vec());
            end
        end
        n_cmp++;
        if (running !== 1'b1) begin
            n_bad++;
            $display("FAIL async_running got=%b want=1", running);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (obs !== 6'b0) begin
            n_bad++;
            $display("FAIL async_reset got=%b want=%b", obs, 6'b0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        wave.delete();
        add_idle(10);
        foreach (wave[i]) begin
            drive_cycle(wave[i]);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL async_after edge=%0d got=%b want=%b",
                         edge_n, obs, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_glitch_pause();
        test_lap();
        test_pause_clear();
        test_simultaneous();
        test_long_press();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Run/lap/clear sequencer for the 8-digit stopwatch datapath.
- Debounces the start and lap push-buttons and runs the mode FSM.
- Generates the count-enable tick that advances the BCD time counters.
- Generates the clear pulse that zeroes the counters and the freeze level that latches the display during a lap.
- Sits between the board buttons and the time counter / 7-segment mux.

Parameters:
DEBOUNCE_CYCLES, 20, consecutive stable synchronized samples required before a button level is accepted (>=1)
TICK_DIV, 10, clk cycles per tick pulse while counting (>=2)
LONG_PRESS, 1000, debounced cycles start must be held to force clear (> DEBOUNCE_CYCLES)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
btn_start  in  1  raw start/stop button, active-high, asynchronous to clk
btn_lap  in  1  raw lap/reset button, active-high, asynchronous to clk
tick  out  1  one-cycle count-enable pulse to the time counters
clr  out  1  one-cycle synchronous clear to the time counters
disp_freeze  out  1  level; display holds its last latched value while high
running  out  1  level; high in RUN or LAP
state  out  2  FSM state: 0 IDLE, 1 RUN, 2 PAUSE, 3 LAP

Behaviour:
Reset (async):
- All registers clear: state=IDLE, tick=0, clr=0, disp_freeze=0, running=0.
- Synchronizers, debounce counters, debounced levels, hold counter and prescaler all go to 0.

Input conditioning (per button, identical):
- 2-FF synchronizer.
- Debounce counter counts consecutive cycles where the synchronized level differs from the debounced level.
- Counter resets to 0 on any cycle where the levels agree.
- When the count reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
- Press event = 1-cycle pulse on the debounced rising edge. Release produces no event.
- Latency for a clean press: first edge sampling btn high = edge 0. The debounced level rises at edge DEBOUNCE_CYCLES+2. state/running/disp_freeze change at edge DEBOUNCE_CYCLES+3.
- Glitches shorter than DEBOUNCE_CYCLES cycles produce no event.

FSM transitions (evaluated on press events):
- IDLE: start -> RUN. lap ignored.
- RUN: start -> PAUSE. lap -> LAP.
- LAP: lap -> RUN. start -> PAUSE.
- PAUSE: start -> RUN. lap -> IDLE with clr.
- Start and lap events in the same cycle: start wins, lap is discarded.

Long press:
- Hold counter increments each cycle while debounced start is high, saturating at LONG_PRESS. It clears when debounced start is low.
- On the cycle it reaches LONG_PRESS, from any state: state -> IDLE and clr pulses. This overrides any lap event in that cycle.
- The short-press action taken on the rising edge is not undone. Release after a long press produces no action.

Outputs (all registered):
- running = (state==RUN or LAP).
- disp_freeze = (state==LAP).
- clr is high exactly one cycle, coincident with the first cycle state reads IDLE after a clear transition. It is never asserted on reset.
- Entering IDLE from PAUSE via lap, or via long press, always pulses clr.

Tick prescaler:
- Counter 0..TICK_DIV-1 advances only while the next state is RUN or LAP.
- tick=1 for the cycle following the counter being at TICK_DIV-1; the counter then wraps to 0.
- In PAUSE the counter holds its value, so the partial interval is preserved.
- The counter is forced to 0 whenever state is IDLE or clr is asserted.
- tick is never high in IDLE or PAUSE, and never in the same cycle as clr.
- First tick after IDLE->RUN arrives exactly TICK_DIV cycles after running rises.
- Counter widths are derived from the parameters. No overflow is possible: counters saturate or wrap as stated.

Test Plan:
(Bench parameters: DEBOUNCE_CYCLES=4, TICK_DIV=5, LONG_PRESS=40.)
1. Reset, then clean start press held 10 cycles -> running rises at edge 7 after first high sample. Ticks follow every 5 cycles (first 5 cycles after running rises). clr stays 0.
2. RUN, 3-cycle start glitch -> no state change, ticks uninterrupted. A 6-cycle start press -> PAUSE, ticks stop. Second press -> RUN, next tick arrives after the remaining prescaler count.
3. RUN, lap press -> state=3, disp_freeze=1, ticks continue. Lap press again -> state=1, disp_freeze=0.
4. PAUSE, lap press -> state=0, clr high exactly 1 cycle, prescaler zeroed, no tick.
5. Start and lap debounced rising in the same cycle from RUN -> PAUSE, disp_freeze stays 0.
6. Start held 60 cycles from IDLE -> RUN after edge 7, then IDLE with a single clr pulse when the hold counter hits 40. Release produces no event. Async rst asserted mid-RUN -> all outputs 0 immediately.
